dmem_port_arbiter: RTL and testbench

- Shares the single DataMemory port between NUM_CORES pipeline MEM stages of the multicore processor.
- Round-robin arbitration with a registered priority pointer.
- Muxes the granted core's command onto the memory port.
- Returns per-core stall so each losing core freezes its EX/MEM register until served.
- Sits between the cores' EX/MEM pipeline registers and DataMemory; the memory keeps combinational reads and posedge writes.

---
 rtl/dmem_port_arbiter_if.sv | 39 +++
 rtl/dmem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the cores' MEM stages, the data-memory arbiter and DataMemory.
// The arbiter connects through the slave modport; cores and memory use master.
interface dmem_port_arbiter_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0]    Core_Req;
    logic [NUM_CORES-1:0]    Core_MemWrite;
    logic [NUM_CORES-1:0]    Core_HalfControl;
    logic [NUM_CORES-1:0]    Core_ByteControl;
    logic [NUM_CORES-1:0]    Core_Lock;
    logic [32*NUM_CORES-1:0] Core_Address;
    logic [32*NUM_CORES-1:0] Core_WriteData;
    logic [NUM_CORES-1:0]    Core_Stall;
    logic [31:0]             Core_ReadData;
    logic [NUM_CORES-1:0]    Grant;
    logic [31:0]             Mem_Address;
    logic [31:0]             Mem_WriteData;
    logic                    Mem_MemRead;
    logic                    Mem_MemWrite;
    logic                    Mem_HalfControl;
    logic                    Mem_ByteControl;
    logic [31:0]             Mem_ReadData;

    modport slave (
        input  Core_Req, Core_MemWrite, Core_HalfControl, Core_ByteControl, Core_Lock,
        input  Core_Address, Core_WriteData, Mem_ReadData,
        output Core_Stall, Core_ReadData, Grant,
        output Mem_Address, Mem_WriteData, Mem_MemRead, Mem_MemWrite,
        output Mem_HalfControl, Mem_ByteControl
    );

    modport master (
        output Core_Req, Core_MemWrite, Core_HalfControl, Core_ByteControl, Core_Lock,
        output Core_Address, Core_WriteData, Mem_ReadData,
        input  Core_Stall, Core_ReadData, Grant,
        input  Mem_Address, Mem_WriteData, Mem_MemRead, Mem_MemWrite,
        input  Mem_HalfControl, Mem_ByteControl
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one DataMemory port among NUM_CORES MEM stages.
// Define DMEM_ARB_LOCK_EN to add bounded bus locking for atomic read-modify-write.
module dmem_port_arbiter #(
    parameter int NUM_CORES       = 4,
    parameter int PTR_W           = 2,
    parameter int MAX_LOCK_CYCLES = 8
) (
    input logic                Clk,
    input logic                Reset,
    dmem_port_arbiter_if.slave bus
);

    if (PTR_W != $clog2(NUM_CORES) || NUM_CORES < 2 || MAX_LOCK_CYCLES < 1) begin : g_cfg_err
        $error("dmem_port_arbiter: inconsistent NUM_CORES/PTR_W/MAX_LOCK_CYCLES");
    end

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_idx;
    logic                 rr_vld;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 gnt_vld;
    logic                 gnt_act;
    logic [NUM_CORES-1:0] grant_oh;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_we;
    logic                 mem_half;
    logic                 mem_byte;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_CORES - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    // First requester at or after rr_ptr, wrapping past the last core.
    always_comb begin
        int               c;
        logic [PTR_W-1:0] ci;
        rr_vld = 1'b0;
        rr_idx = '0;
        c      = 0;
        ci     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            c = int'(rr_ptr) + k;
            if (c >= NUM_CORES)
                c = c - NUM_CORES;
            ci = PTR_W'(c);
            if (!rr_vld && bus.Core_Req[ci]) begin
                rr_vld = 1'b1;
                rr_idx = ci;
            end
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    localparam int LCNT_W = ($clog2(MAX_LOCK_CYCLES + 1) > 4) ? $clog2(MAX_LOCK_CYCLES + 1) : 4;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t      lock_state;
    logic [PTR_W-1:0] lock_owner;
    logic [LCNT_W-1:0] lock_cnt;
    logic             lock_blk;
    logic             lock_take;

    // lock_blk: the last owner was forcibly released and still holds Lock.
    assign lock_take = rr_vld && bus.Core_Lock[rr_idx] && !(lock_blk && rr_idx == lock_owner);

    always_comb begin
        if (lock_state == LOCKED) begin
            gnt_vld = bus.Core_Req[lock_owner];
            gnt_idx = lock_owner;
        end else begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lock_state <= UNLOCKED;
            lock_owner <= '0;
            lock_cnt   <= '0;
            lock_blk   <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            case (lock_state)
                UNLOCKED: begin
                    if (lock_blk && !bus.Core_Lock[lock_owner])
                        lock_blk <= 1'b0;
                    if (lock_take) begin
                        lock_state <= LOCKED;
                        lock_owner <= rr_idx;
                        lock_cnt   <= LCNT_W'(1);
                        lock_blk   <= 1'b0;
                    end else if (rr_vld) begin
                        rr_ptr <= wrap_inc(rr_idx);
                    end
                end
                LOCKED: begin
                    // lock_cnt includes the cycle that took the lock.
                    if (!bus.Core_Lock[lock_owner] || lock_cnt >= LCNT_W'(MAX_LOCK_CYCLES - 1)) begin
                        lock_state <= UNLOCKED;
                        lock_cnt   <= '0;
                        rr_ptr     <= wrap_inc(lock_owner);
                        lock_blk   <= bus.Core_Lock[lock_owner];
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: lock_state <= UNLOCKED;
            endcase
        end
    end
`else
    assign gnt_vld = rr_vld;
    assign gnt_idx = rr_idx;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            rr_ptr <= '0;
        else if (rr_vld)
            rr_ptr <= wrap_inc(rr_idx);
    end
`endif

    // Reset also gates the outputs combinationally so the port is quiet while held.
    assign gnt_act = gnt_vld & Reset;

    always_comb begin
        grant_oh  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_half  = 1'b0;
        mem_byte  = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt_act && gnt_idx == PTR_W'(i)) begin
                grant_oh[i] = 1'b1;
                mem_addr    = bus.Core_Address[32*i +: 32];
                mem_wdata   = bus.Core_WriteData[32*i +: 32];
                mem_we      = bus.Core_MemWrite[i];
                mem_half    = bus.Core_HalfControl[i];
                mem_byte    = bus.Core_ByteControl[i];
            end
        end
    end

    assign bus.Grant           = grant_oh;
    assign bus.Core_Stall      = bus.Core_Req & ~grant_oh;
    assign bus.Mem_Address     = mem_addr;
    assign bus.Mem_WriteData   = mem_wdata;
    assign bus.Mem_MemWrite    = mem_we;
    assign bus.Mem_MemRead     = gnt_act & ~mem_we;
    assign bus.Mem_HalfControl = mem_half;
    assign bus.Mem_ByteControl = mem_byte;
    assign bus.Core_ReadData   = gnt_act ? bus.Mem_ReadData : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: reference arbitration model checked every cycle,
// plus directed scenarios with literal expectations; behaves as DataMemory itself.
module tb_dmem_port_arbiter;
    localparam int N   = 4;
    localparam int MAX = 8;

    logic Clk = 1'b0;
    logic Reset;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] mem [64];

    dmem_port_arbiter_if #(.NUM_CORES(N)) bus ();

    dmem_port_arbiter #(.NUM_CORES(N), .PTR_W(2), .MAX_LOCK_CYCLES(MAX)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    assign bus.Mem_ReadData = mem[bus.Mem_Address[7:2]];

    always @(posedge Clk)
        if (bus.Mem_MemWrite)
            mem[bus.Mem_Address[7:2]] = bus.Mem_WriteData;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pointer, lock ownership and hold count as plain integers.
    int m_ptr    = 0;
    int m_locked = 0;
    int m_owner  = 0;
    int m_held   = 0;
    int m_blk    = 0;

    always @(negedge Clk) begin
        int          g;
        logic [3:0]  eg;
        logic [31:0] ea;
        logic [31:0] ed;
        g = -1;
        if (Reset) begin
            if (m_locked != 0) begin
                if (bus.Core_Req[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && bus.Core_Req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        eg = (g >= 0) ? 4'(1 << g) : 4'b0;
        ea = (g >= 0) ? bus.Core_Address[32*g +: 32] : 32'h0;
        ed = (g >= 0) ? bus.Core_WriteData[32*g +: 32] : 32'h0;
        check("m_grant", {28'h0, bus.Grant}, {28'h0, eg});
        check("m_stall", {28'h0, bus.Core_Stall}, {28'h0, bus.Core_Req & ~eg});
        check("m_addr", bus.Mem_Address, ea);
        check("m_wdata", bus.Mem_WriteData, ed);
        check("m_we", {31'h0, bus.Mem_MemWrite}, {31'h0, g >= 0 && bus.Core_MemWrite[g]});
        check("m_re", {31'h0, bus.Mem_MemRead}, {31'h0, g >= 0 && !bus.Core_MemWrite[g]});
        check("m_half", {31'h0, bus.Mem_HalfControl}, {31'h0, g >= 0 && bus.Core_HalfControl[g]});
        check("m_byte", {31'h0, bus.Mem_ByteControl}, {31'h0, g >= 0 && bus.Core_ByteControl[g]});
        check("m_rdata", bus.Core_ReadData, (g >= 0) ? mem[ea[7:2]] : 32'h0);

        // State after the coming rising edge (inputs only change just after it).
        if (!Reset) begin
            m_ptr = 0; m_locked = 0; m_owner = 0; m_held = 0; m_blk = 0;
        end else if (m_locked != 0) begin
            m_held++;
            if (!bus.Core_Lock[m_owner] || m_held >= MAX) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % N;
                m_blk    = bus.Core_Lock[m_owner] ? 1 : 0;
                m_held   = 0;
            end
        end else begin
`ifdef DMEM_ARB_LOCK_EN
            if (m_blk != 0 && !bus.Core_Lock[m_owner]) m_blk = 0;
            if (g >= 0 && bus.Core_Lock[g] && !(m_blk != 0 && g == m_owner)) begin
                m_locked = 1; m_owner = g; m_held = 1; m_blk = 0;
            end else if (g >= 0) begin
                m_ptr = (g + 1) % N;
            end
`else
            if (g >= 0) m_ptr = (g + 1) % N;
`endif
        end
    end

    task automatic next();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] mw, input logic [3:0] lk);
        bus.Core_Req      = req;
        bus.Core_MemWrite = mw;
        bus.Core_Lock     = lk;
    endtask

    task automatic set_core(input int i, input logic [31:0] a, input logic [31:0] d);
        bus.Core_Address[32*i +: 32]   = a;
        bus.Core_WriteData[32*i +: 32] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    logic [3:0] rot_exp [5];
    logic [3:0] vec_req [8];
    logic [3:0] vec_mw  [8];

    initial begin
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        vec_req = '{4'b0101, 4'b1001, 4'b1111, 4'b0110, 4'b1000, 4'b0011, 4'b1110, 4'b0000};
        vec_mw  = '{4'b0001, 4'b1000, 4'b1010, 4'b0100, 4'b0000, 4'b0011, 4'b0010, 4'b1111};
        for (int i = 0; i < 64; i++) mem[i] = 32'h0101_0101 * i;
        mem[4] = 32'hDEAD_BEEF;
        Reset = 1'b0;
        bus.Core_HalfControl = 4'b0000;
        bus.Core_ByteControl = 4'b0000;
        bus.Core_Address     = '0;
        bus.Core_WriteData   = '0;
        drive(4'b1111, 4'b0000, 4'b0000);

        next(); next(); #2;
        check("rst_grant", {28'h0, bus.Grant}, 32'h0);
        check("rst_stall", {28'h0, bus.Core_Stall}, 32'hF);
        check("rst_re", {31'h0, bus.Mem_MemRead}, 32'h0);
        check("rst_we", {31'h0, bus.Mem_MemWrite}, 32'h0);
        check("rst_rdata", bus.Core_ReadData, 32'h0);

        next(); Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("rot_grant", {28'h0, bus.Grant}, {28'h0, rot_exp[i]});
            check("rot_stall", {28'h0, bus.Core_Stall}, {28'h0, ~rot_exp[i]});
            next();
        end

        set_core(2, 32'h10, 32'h0);
        drive(4'b0100, 4'b0000, 4'b0000); #2;
        check("rd_grant", {28'h0, bus.Grant}, 32'h4);
        check("rd_addr", bus.Mem_Address, 32'h10);
        check("rd_re", {31'h0, bus.Mem_MemRead}, 32'h1);
        check("rd_data", bus.Core_ReadData, 32'hDEAD_BEEF);
        check("rd_stall", {28'h0, bus.Core_Stall}, 32'h0);

        next();
        set_core(1, 32'h4, 32'h1111_1111);
        set_core(3, 32'h8, 32'h3333_3333);
        drive(4'b1010, 4'b1010, 4'b0000); #2;
        check("wr3_grant", {28'h0, bus.Grant}, 32'h8);
        check("wr3_stall", {28'h0, bus.Core_Stall}, 32'h2);
        check("wr3_data", bus.Mem_WriteData, 32'h3333_3333);
        next();
        drive(4'b0010, 4'b0010, 4'b0000); #2;
        check("wr1_grant", {28'h0, bus.Grant}, 32'h2);
        check("wr1_addr", bus.Mem_Address, 32'h4);
        next();
        drive(4'b0000, 4'b0000, 4'b0000); #2;
        check("idle_grant", {28'h0, bus.Grant}, 32'h0);
        check("idle_en", {30'h0, bus.Mem_MemRead, bus.Mem_MemWrite}, 32'h0);
        check("idle_addr", bus.Mem_Address, 32'h0);
        check("mem1", mem[1], 32'h1111_1111);
        check("mem2", mem[2], 32'h3333_3333);

        next();
        drive(4'b0100, 4'b0000, 4'b0000); #2;
        check("pre_wrap", {28'h0, bus.Grant}, 32'h4);
        next();
        set_core(0, 32'h0, 32'h0);
        drive(4'b0001, 4'b0000, 4'b0000); #2;
        check("wrap_grant", {28'h0, bus.Grant}, 32'h1);
        next();
        drive(4'b0000, 4'b0000, 4'b0000);
        next();
        drive(4'b1111, 4'b0000, 4'b0000); #2;
        check("ptr_after_wrap", {28'h0, bus.Grant}, 32'h2);

        bus.Core_HalfControl = 4'b0101;
        bus.Core_ByteControl = 4'b1010;
        for (int i = 0; i < 4; i++) set_core(i, 32'h20 + 32'(i * 4), 32'hA0A0_0000 + 32'(i));
        for (int i = 0; i < 8; i++) begin
            next();
            drive(vec_req[i], vec_mw[i], 4'b0000);
        end

        next();
        drive(4'b1111, 4'b0000, 4'b0000); #2;
        Reset = 1'b0; #1;
        check("arst_grant", {28'h0, bus.Grant}, 32'h0);
        check("arst_stall", {28'h0, bus.Core_Stall}, 32'hF);
        check("arst_re", {31'h0, bus.Mem_MemRead}, 32'h0);
        next(); Reset = 1'b1; #2;
        check("arst_rel", {28'h0, bus.Grant}, 32'h1);

        next();
        drive(4'b0111, 4'b0000, 4'b0010); #2;
`ifdef DMEM_ARB_LOCK_EN
        for (int i = 0; i < MAX; i++) begin
            check("lock_grant", {28'h0, bus.Grant}, 32'h2);
            next(); #2;
        end
        check("lock_release", {28'h0, bus.Grant}, 32'h4);
`else
        check("nolock_g1", {28'h0, bus.Grant}, 32'h2);
        next(); #2;
        check("nolock_g2", {28'h0, bus.Grant}, 32'h4);
        next(); #2;
        check("nolock_g0", {28'h0, bus.Grant}, 32'h1);
        next(); #2;
        check("nolock_g1b", {28'h0, bus.Grant}, 32'h2);
`endif
        next();
        drive(4'b0000, 4'b0000, 4'b0000);
        next(); next();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
